// File: rtl/mgt_01_booth_multiplier.sv
// mgt_01_booth_multiplier: sequential radix-2 Booth multiplier, one partial-product step per enabled clock
module mgt_01_booth_multiplier #(
   parameter int WIDTH = 25
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clk_en_i,
   input  logic                 start_i,
   input  logic [WIDTH-1:0]     multiplicand_i,
   input  logic [WIDTH-1:0]     multiplier_i,
   output logic [2*WIDTH-1:0]   product_o,
   output logic                 valid_o,
   output logic                 busy_o
);
   localparam int CW = $clog2(WIDTH) + 1;
   typedef enum logic [1:0] {IDLE, MULTIPLY, FINALIZE, VALID} state_t;
   state_t           state_q;
   logic [WIDTH:0]   m_q, acc_q, sum_d;
   logic [WIDTH-1:0] q_q;
   logic             qm1_q;
   logic [CW-1:0]    cnt_q;
   // extra acc bit keeps acc - M exact when M is the most negative operand
   always_comb sum_d = ({q_q[0], qm1_q} == 2'b01) ? acc_q + m_q :
                       ({q_q[0], qm1_q} == 2'b10) ? acc_q - m_q : acc_q;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         m_q       <= '0;
         q_q       <= '0;
         qm1_q     <= 1'b0;
         product_o <= '0;
         valid_o   <= 1'b0;
         busy_o    <= 1'b0;
      end else if (clk_en_i) begin
         case (state_q)
            IDLE: if (start_i) begin
               m_q     <= {multiplicand_i[WIDTH-1], multiplicand_i};
               q_q     <= multiplier_i;
               acc_q   <= '0;
               qm1_q   <= 1'b0;
               cnt_q   <= '0;
               busy_o  <= 1'b1;
               state_q <= MULTIPLY;
            end
            MULTIPLY: begin
               acc_q <= {sum_d[WIDTH], sum_d[WIDTH:1]};
               q_q   <= {sum_d[0], q_q[WIDTH-1:1]};
               qm1_q <= q_q[0];
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) state_q <= FINALIZE;
            end
            FINALIZE: begin
               product_o <= {acc_q[WIDTH-1:0], q_q};
               valid_o   <= 1'b1;
               busy_o    <= 1'b0;
               state_q   <= VALID;
            end
            VALID: begin
               valid_o <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
